coeff_write_seq: RTL

- Upstream master of the FIR coefficient address decoder: turns a valid/ready stream of coefficient words into single-cycle active-low chip-select/write strobes with a 6-bit address.
- Address bits [5:4] select one of 4 coefficient banks; bits [3:0] select one of 16 taps per bank.
- One update session loads NUM_TAPS coefficients in order, starting at address 0.
- The block owns the write side of the coefficient memory during an update.

---
 rtl/coeff_write_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/coeff_write_seq.sv
// Coefficient write sequencer: turns a valid/ready word stream into single-cycle
// active-low CS/WR strobes. Optional running checksum: COEFF_WRITE_SEQ_CHKSUM_EN.
module coeff_write_seq #(
  parameter int DATA_W   = 16,
  parameter int NUM_TAPS = 64
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic              iCoeffValid,
  input  logic [DATA_W-1:0] iCoeffData,
  output logic              oCoeffReady,
  output logic              oCsn,
  output logic              oWrn,
  output logic [5:0]        oAddr,
  output logic [DATA_W-1:0] oWrData,
  output logic              oBusy,
`ifdef COEFF_WRITE_SEQ_CHKSUM_EN
  output logic [DATA_W-1:0] oChksum,
`endif
  output logic              oDone
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [5:0] LAST_TAP = 6'(NUM_TAPS - 1);

  logic [1:0]        state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [5:0]        addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ready_q, strobe_n_q, busy_q, done_q;
  logic              hs;
  logic              sess_start;

  assign hs         = (state_q == S_LOAD) && iCoeffValid && !iAbort;
  assign sess_start = (state_q == S_IDLE) && iStart && !iAbort;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (sess_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (iAbort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (iCoeffValid) begin
          state_d = S_WRITE;
          addr_d  = cnt_q;
          data_d  = iCoeffData;
        end
      end
      S_WRITE: begin
        if (iAbort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_TAP) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          state_d = S_LOAD;
          cnt_d   = cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they track the state register exactly.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      strobe_n_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ready_q    <= (state_d == S_LOAD);
      strobe_n_q <= (state_d != S_WRITE);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign oCoeffReady = ready_q;
  assign oCsn        = strobe_n_q;
  assign oWrn        = strobe_n_q;
  assign oAddr       = addr_q;
  assign oWrData     = data_q;
  assign oBusy       = busy_q;
  assign oDone       = done_q;

`ifdef COEFF_WRITE_SEQ_CHKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (sess_start || (state_q != S_IDLE && iAbort)) begin
      sum_d = '0;
    end else if (hs) begin
      sum_d = sum_q + iCoeffData;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign oChksum = sum_q;
`endif

endmodule
